// File: rtl/btn_cmd_source.sv
// Debounced up/down button pair driving an 8-bit value; each change launches
// one SPI transfer through a start_tx/tx_done handshake, coalescing while busy.

module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLD_CYCLES     = 13500000,
  parameter int REPEAT_CYCLES   = 2700000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic evt
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  logic          sync1, sync2, stable, stable_q, first;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt, limit;
  logic          press, rpt;

  // hold_cnt == 0 means idle; otherwise it counts cycles since the last event
  assign press = stable_q & ~stable;
  assign limit = first ? HW'(HOLD_CYCLES) : HW'(REPEAT_CYCLES);
  assign rpt   = REPEAT_EN && !stable && (hold_cnt != '0) && (hold_cnt == limit);
  assign evt   = press | rpt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_q <= 1'b1;
      first    <= 1'b1;
      db_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 == stable)
        db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;

      if (stable)
        hold_cnt <= '0;
      else if (press) begin
        hold_cnt <= HW'(1);
        first    <= 1'b1;
      end else if (rpt) begin
        hold_cnt <= HW'(1);
        first    <= 1'b0;
      end else if (REPEAT_EN && hold_cnt != '0)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

module btn_cmd_source #(
  parameter int         DEBOUNCE_CYCLES = 270000,
  parameter int         HOLD_CYCLES     = 13500000,
  parameter int         REPEAT_CYCLES   = 2700000,
  parameter bit         REPEAT_EN       = 1'b1,
  parameter logic [7:0] INIT_VALUE      = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       start_tx,
  output logic [7:0] value,
  output logic       busy
);
  localparam int NUM_BTN = 2;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t             state;
  logic               dirty;
  logic [NUM_BTN-1:0] btn_raw, evt;

  assign btn_raw = {btn2, btn1};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (REPEAT_EN)
      ) u_chan (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_raw[i]),
        .evt  (evt[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= INIT_VALUE;
      tx_data  <= INIT_VALUE;
      start_tx <= 1'b0;
      busy     <= 1'b0;
      dirty    <= 1'b0;
      state    <= IDLE;
    end else begin
      case (state)
        IDLE: if (dirty) begin
          tx_data  <= value;
          start_tx <= 1'b1;
          dirty    <= 1'b0;
          busy     <= 1'b1;
          state    <= BUSY;
        end
        BUSY: if (tx_done) begin
          start_tx <= 1'b0;
          state    <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          start_tx <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
      // placed after the launch so a change on the launch edge keeps dirty set
      if (evt[0] ^ evt[1]) begin
        value <= evt[0] ? value + 8'd1 : value - 8'd1;
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btn_cmd_source.sv
// Bench for btn_cmd_source: scoreboarded transfers with a tx_done responder.

module tb_btn_cmd_source;
  logic       clk = 1'b0, reset, btn1, btn2, tx_done;
  logic [7:0] tx_data, value;
  logic       start_tx, busy;

  btn_cmd_source #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1'b1), .INIT_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .tx_done(tx_done),
    .tx_data(tx_data), .start_tx(start_tx), .value(value), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int n_rise = 0, rise_cyc = 0, vchg_cyc = 0, done_cyc = 0, fall_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_tx = 8'h00, held_tx = 8'h00, prev_val = 8'h00;
  logic prev_st = 1'b0, rsp_prev = 1'b0, gap_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: scoreboard pops on each launch, tx_data must hold while start_tx
  always @(negedge clk) begin
    if (value != prev_val) vchg_cyc = cyc;
    if (tx_done) done_cyc = cyc;
    if (start_tx && !prev_st) begin
      rise_cyc = cyc;
      n_rise++;
      last_tx = tx_data;
      held_tx = tx_data;
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end else if (start_tx)
      chk("tx_hold", tx_data, held_tx);
    if (!start_tx && prev_st) fall_cyc = cyc;
    if (busy && !start_tx) gap_seen = 1'b1;
    prev_st  = start_tx;
    prev_val = value;
  end

  // SPI master model: tx_done sampled 10 cycles after start_tx rises
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start_tx && !rsp_prev) begin
        repeat (9) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
      rsp_prev = start_tx;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_btns(input logic b1, input logic b2, input int n);
    btn1 = b1;
    btn2 = b2;
    idle(n);
    btn1 = 1'b1;
    btn2 = 1'b1;
  endtask

  int n0;

  initial begin
    btn1 = 1'b1; btn2 = 1'b1; reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(50);
    chk("rst_value", value, 8'h00);
    chk("rst_start", start_tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txd", tx_data, 8'h00);

    // single increment, latency and handshake timing
    n0 = n_rise;
    exp_q.push_back(8'h01);
    hold_btns(1'b0, 1'b1, 10);
    idle(40);
    chk("up_value", value, 8'h01);
    chk("up_ntx", n_rise - n0, 1);
    chk("up_lat", rise_cyc - vchg_cyc, 1);
    chk("up_fall", fall_cyc - done_cyc, 1);
    chk("up_q", exp_q.size(), 0);
    chk("up_busy", busy, 0);

    // bounce shorter than the debounce window
    n0 = n_rise;
    for (int i = 0; i < 10; i++) begin
      btn1 = 1'b0; idle(2);
      btn1 = 1'b1; idle(2);
    end
    idle(20);
    chk("glitch_value", value, 8'h01);
    chk("glitch_ntx", n_rise - n0, 0);

    // wrap both directions
    reset = 1'b1; idle(2); reset = 1'b0; idle(5);
    exp_q.push_back(8'hFF);
    hold_btns(1'b1, 1'b0, 10);
    idle(40);
    chk("wrap_dn_value", value, 8'hFF);
    chk("wrap_dn_tx", last_tx, 8'hFF);
    exp_q.push_back(8'h00);
    hold_btns(1'b0, 1'b1, 10);
    idle(40);
    chk("wrap_up_value", value, 8'h00);
    chk("wrap_q", exp_q.size(), 0);

    // auto-repeat with coalesced transfers
    n0 = n_rise;
    gap_seen = 1'b0;
    hold_btns(1'b0, 1'b1, 50);
    idle(60);
    chk("rpt_value", value, 8'h05);
    chk("rpt_last_tx", last_tx, 8'h05);
    chk("rpt_multi", (n_rise - n0) >= 2, 1);
    chk("rpt_gap", gap_seen, 1);

    // simultaneous up and down cancel
    n0 = n_rise;
    hold_btns(1'b0, 1'b0, 10);
    idle(40);
    chk("both_value", value, 8'h05);
    chk("both_ntx", n_rise - n0, 0);

    // reset while a transfer is outstanding
    exp_q.push_back(8'h06);
    btn1 = 1'b0;
    for (int i = 0; i < 40 && !start_tx; i++) idle(1);
    chk("mid_start_seen", start_tx, 1);
    reset = 1'b1;
    btn1  = 1'b1;
    idle(1);
    chk("mid_start", start_tx, 0);
    chk("mid_value", value, 8'h00);
    chk("mid_busy", busy, 0);
    reset = 1'b0;
    n0 = n_rise;
    idle(40);
    chk("mid_relaunch", n_rise - n0, 0);
    chk("mid_value2", value, 8'h00);
    chk("mid_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_cmd_source.md
Name: btn_cmd_source

Overview:
- Upstream stage of the SPI master: turns two raw active-low push buttons into a debounced up/down 8-bit value and launches one SPI transfer per value change.
- Drives the master's tx_data/start_tx pair and consumes its tx_done pulse.
- Replaces the ad-hoc button counting in the top level with a self-contained, handshake-correct block.

Parameters:
- DEBOUNCE_CYCLES, 270000, consecutive cycles a synchronised button level must differ from the stable level before it is accepted (10 ms @ 27 MHz).
- HOLD_CYCLES, 13500000, cycles a button must stay pressed after its press event before the first auto-repeat event.
- REPEAT_CYCLES, 2700000, cycles between subsequent auto-repeat events while held.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives one event per press.
- INIT_VALUE, 8'h00, value loaded on reset.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn1  in  1  raw increment button, active-low, asynchronous to clk.
- btn2  in  1  raw decrement button, active-low, asynchronous to clk.
- tx_done  in  1  one-cycle pulse from the SPI master at end of transfer.
- tx_data  out  8  byte presented to the SPI master; stable while start_tx=1.
- start_tx  out  1  transfer request level; held high until tx_done is seen.
- value  out  8  current up/down value (for LEDs).
- busy  out  1  high while a transfer is outstanding (state BUSY or GAP).

Behaviour:
- Reset values: value=INIT_VALUE, tx_data=INIT_VALUE, start_tx=0, busy=0. Stable button levels=1 (released), all counters=0, dirty=0, state=IDLE. Reset mid-transfer drops start_tx on the next edge; no transfer is relaunched.
- Synchroniser: 2-FF per button; all logic uses the synchronised level.
- Debounce, per button:
  - Counter clears whenever synced==stable, else increments.
  - On reaching DEBOUNCE_CYCLES-1 while still differing: stable<=synced, counter<=0.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- Events, per button:
  - Press event: one-cycle pulse on the edge where stable goes 1->0.
  - If REPEAT_EN: hold counter starts at the press event. First repeat event after HOLD_CYCLES cycles, then every REPEAT_CYCLES cycles while stable=0.
  - Release (stable 0->1) clears the hold counter; no event on release.
- Value update, on the edge after the event pulse:
  - Up only: value+1. Down only: value-1.
  - 8-bit modular wrap: FF+1=00, 00-1=FF.
  - Up and down in the same cycle: no change, dirty not set.
  - Any change sets dirty=1.
- FSM:
  - IDLE: if dirty, then tx_data<=value, start_tx<=1, dirty<=0, go to BUSY. start_tx rises exactly 1 cycle after value changes.
  - BUSY: start_tx=1 and tx_data frozen. Value changes still update value and set dirty. On tx_done: start_tx<=0, go to GAP.
  - GAP: one cycle with start_tx=0 (guarantees a rising edge to the master), then IDLE. A pending dirty relaunches with the latest value, so intermediate values are coalesced.
  - tx_done in IDLE or GAP is ignored.
  - tx_done coinciding with a value change in BUSY: both take effect; the new value is sent on the next launch.
- busy = (state != IDLE).

Test Plan:
(Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, INIT_VALUE=0. Bench model returns tx_done 10 cycles after start_tx rises.)
- Reset then idle 50 cycles -> value=00, start_tx=0, busy=0, tx_data=00.
- btn1 low for 10 cycles, then high -> value=01 once. start_tx rises 1 cycle after the value change with tx_data=01. start_tx falls the cycle after tx_done; exactly one transfer.
- btn1 toggles low/high every 2 cycles for 40 cycles -> no value change, start_tx never asserted.
- Reset, then btn2 press/release once -> value=FF and tx_data=FF (wrap). Then load value=FF, press btn1 -> value=00.
- btn1 held 50 cycles -> press event, then repeat events at +20, +28, +36, +44 cycles -> value=05. Transfers issued during BUSY are coalesced: the last transfer carries tx_data=05 and at least one GAP cycle (start_tx=0) separates transfers.
- Both buttons pressed on the same cycle -> value unchanged, no transfer. Assert reset while start_tx=1 -> start_tx=0 next cycle, value=INIT_VALUE, no relaunch.
